// File: rtl/eth_mdio_master_if.sv
// rtl/eth_mdio_master_if.sv - request/response bus between eth_regs and the MDIO master
interface eth_mdio_master_if;
    logic        Start;
    logic        C45;
    logic [1:0]  Op;
    logic [4:0]  Phy_Addr;
    logic [4:0]  Reg_Addr;
    logic [15:0] Wr_Data;
    logic        Busy;
    logic        Done;
    logic        Rd_Valid;
    logic [15:0] Rd_Data;
    logic        Ta_Err;

    modport master (
        output Start, C45, Op, Phy_Addr, Reg_Addr, Wr_Data,
        input  Busy, Done, Rd_Valid, Rd_Data, Ta_Err
    );

    modport slave (
        input  Start, C45, Op, Phy_Addr, Reg_Addr, Wr_Data,
        output Busy, Done, Rd_Valid, Rd_Data, Ta_Err
    );
endinterface

// File: rtl/eth_mdio_master.sv
// rtl/eth_mdio_master.sv - MDIO management master serialising Clause 22/45 frames
module eth_mdio_master #(
    parameter int CLK_DIV      = 10,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    eth_mdio_master_if.slave Bus,
    output logic             MDC,
    output logic             MDIO_O,
    output logic             MDIO_OE,
    input  logic             MDIO_I
);
    localparam int PW = $clog2(2 * CLK_DIV);
    localparam logic [PW-1:0] PH_LAST     = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] PH_PRE_RISE = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_RISE     = PW'(CLK_DIV);
    localparam logic [4:0]    PRE_LAST    = (PREAMBLE_LEN > 0) ? 5'(PREAMBLE_LEN - 1) : 5'd0;

    typedef enum logic [3:0] {IDLE, PRE, ST, OP, PA, RA, TA, DATA, END} state_t;
    localparam state_t FIRST = (PREAMBLE_LEN > 0) ? PRE : ST;

    state_t          state, nextState;
    logic [PW-1:0]   phase;
    logic [4:0]      bitCnt;
    logic [4:0]      lastIdx;
    logic [31:0]     frame;     // ST..DATA, MSB is the bit on the wire
    logic [15:0]     rdShift;
    logic            isRead;
    logic            taSample;
    logic            mdcReg;
    logic            bitEnd;
    logic            lastBit;
    logic            inFrame;

    assign bitEnd  = (phase == PH_LAST);
    assign lastBit = bitEnd && (bitCnt == lastIdx);
    assign inFrame = (state != IDLE) && (state != END);
    assign MDC     = mdcReg;

    // Index of the final bit of the field currently being sent
    always_comb begin
        lastIdx = 5'd0;
        case (state)
            PRE:        lastIdx = PRE_LAST;
            ST, OP, TA: lastIdx = 5'd1;
            PA, RA:     lastIdx = 5'd4;
            DATA:       lastIdx = 5'd15;
            default:    lastIdx = 5'd0;
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= nextState;
    end

    // Field sequencing: advance after the last bit of each field
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (Bus.Start) nextState = FIRST;
            PRE:     if (lastBit) nextState = ST;
            ST:      if (lastBit) nextState = OP;
            OP:      if (lastBit) nextState = PA;
            PA:      if (lastBit) nextState = RA;
            RA:      if (lastBit) nextState = TA;
            TA:      if (lastBit) nextState = DATA;
            DATA:    if (lastBit) nextState = END;
            END:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Pin and status decode; reads release MDIO from the turnaround onwards
    always_comb begin
        MDIO_OE      = 1'b0;
        case (state)
            PRE, ST, OP, PA, RA: MDIO_OE = 1'b1;
            TA, DATA:            MDIO_OE = !isRead;
            default:             MDIO_OE = 1'b0;
        endcase
        MDIO_O       = MDIO_OE && ((state == PRE) || frame[31]);
        Bus.Busy     = (state != IDLE);
        Bus.Done     = (state == END);
        Bus.Rd_Valid = (state == END) && isRead;
    end

    // Bit timing, frame shifter, MDIO_I capture and result registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            phase       <= '0;
            bitCnt      <= 5'd0;
            frame       <= 32'd0;
            rdShift     <= 16'd0;
            isRead      <= 1'b0;
            taSample    <= 1'b0;
            mdcReg      <= 1'b0;
            Bus.Rd_Data <= 16'd0;
            Bus.Ta_Err  <= 1'b0;
        end else if (state == IDLE) begin
            if (Bus.Start) begin
                phase    <= '0;
                bitCnt   <= 5'd0;
                mdcReg   <= 1'b0;
                taSample <= 1'b0;
                isRead   <= Bus.Op[1];
                frame    <= {1'b0, !Bus.C45, Bus.Op, Bus.Phy_Addr, Bus.Reg_Addr,
                             Bus.Op[1] ? 2'b00 : 2'b10,
                             Bus.Op[1] ? 16'h0000 : Bus.Wr_Data};
            end
        end else if (inFrame) begin
            if (bitEnd) begin
                phase  <= '0;
                mdcReg <= 1'b0;
                bitCnt <= lastBit ? 5'd0 : bitCnt + 5'd1;
                if (state != PRE) frame <= {frame[30:0], 1'b0};
            end else begin
                phase <= phase + PW'(1);
                if (phase == PH_PRE_RISE) mdcReg <= 1'b1;
            end
            // MDIO_I is taken during the first Clk cycle with MDC high
            if (phase == PH_RISE) begin
                if (state == TA && bitCnt == 5'd1) taSample <= MDIO_I;
                if (state == DATA) rdShift <= {rdShift[14:0], MDIO_I};
            end
            if (state == DATA && lastBit) begin
                if (isRead) Bus.Rd_Data <= rdShift;
                Bus.Ta_Err <= isRead && taSample;
            end
        end
    end
endmodule
